fdct_sched: RTL

FDCT_SCHED -- requirements
Module: fdct_sched

---
 rtl/fdct_sched.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/fdct_sched.sv
// fdct_sched: frame scheduler wrapped around an 8x8 forward-DCT datapath.
// Pixels are admitted one 64-pixel block at a time, and only when the output
// buffer is guaranteed room for that block's 64 coefficients. The guarantee is
// credit based: buffered coefficients plus inflight coefficients plus 64 must
// not exceed DEPTH.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid never waits on ready. pix_ready depends only on the
// registered state. coef_valid/coef_out depend only on registered buffer state.
// The fdct output side has no ready, so every fdct_dout_valid cycle is a push.
module fdct_sched #(
    parameter int FIFO_BLOCKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] cfg_num_blocks,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  fdct_din,
    output logic        fdct_din_valid,
    output logic        fdct_nrst,
    input  logic [7:0]  fdct_dout,
    input  logic        fdct_dout_valid,
    output logic [7:0]  coef_out,
    output logic        coef_valid,
    input  logic        coef_ready,
    output logic        coef_last,
    output logic        busy,
    output logic        frame_done,
    output logic        err,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 64 * FIFO_BLOCKS;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW:0]   C_BLK_WIDE   = (CW + 1)'(64);
    localparam logic [CW:0]   C_DEPTH_WIDE = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] C_BLK        = CW'(64);
    localparam logic [CW-1:0] C_DEPTH      = CW'(DEPTH);
    localparam logic [AW-1:0] C_LAST_PTR   = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADMIT = 2'd1,
        S_FEED  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          r_state;
    logic [15:0]     r_num_blocks;
    logic [15:0]     r_fed_blocks;
    logic [5:0]      r_pix_cnt;
    logic [5:0]      r_pop_cnt;
    logic [21:0]     r_coef_cnt;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [7:0]      r_mem [DEPTH];
    logic            r_nrst;
    logic            r_frame_done;
    logic            r_err;

    logic            w_feed;
    logic            w_pix_hs;
    logic            w_last_fed;
    logic            w_credit_ok;
    logic            w_admit;
    logic            w_start_ok;
    logic            w_full;
    logic            w_empty;
    logic            w_dout_ok;
    logic            w_push;
    logic            w_push_err;
    logic            w_pop;
    logic [21:0]     w_frame_total;
    logic            w_last_pop;

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    assign w_feed        = (r_state == S_FEED);
    assign w_pix_hs      = w_feed && pix_valid;
    assign w_last_fed    = ((r_fed_blocks + 16'd1) == r_num_blocks);
    assign w_credit_ok   = ({1'b0, r_count} + {1'b0, r_inflight} + C_BLK_WIDE) <= C_DEPTH_WIDE;
    assign w_admit       = (r_state == S_ADMIT) && w_credit_ok;
    assign w_start_ok    = (r_state == S_IDLE) && start;
    assign w_full        = (r_count == C_DEPTH);
    assign w_empty       = (r_count == '0);
    assign w_dout_ok     = fdct_dout_valid && (r_inflight != '0);
    assign w_push        = w_dout_ok && !w_full;
    assign w_push_err    = fdct_dout_valid && ((r_inflight == '0) || w_full);
    assign w_pop         = !w_empty && coef_ready;
    assign w_frame_total = {r_num_blocks, 6'd0};
    assign w_last_pop    = w_pop && ((r_coef_cnt + 22'd1) == w_frame_total);

    assign pix_ready      = w_feed;
    assign fdct_din_valid = w_pix_hs;
    assign fdct_din       = w_feed ? pix_in : 8'd0;
    assign coef_valid     = !w_empty;
    assign coef_out       = w_empty ? 8'd0 : r_mem[r_rd];
    assign coef_last      = !w_empty && (r_pop_cnt == 6'd63);
    assign busy           = (r_state != S_IDLE);
    assign frame_done     = r_frame_done;
    assign err            = r_err;
    assign fdct_nrst      = r_nrst;
    assign dbg_state      = r_state;

    // Frame FSM: block admission, pixel counting and the frame-done pulse.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_state      <= S_IDLE;
            r_num_blocks <= '0;
            r_fed_blocks <= '0;
            r_pix_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_num_blocks == 16'd0) begin
                            r_frame_done <= 1'b1;
                        end else begin
                            r_num_blocks <= cfg_num_blocks;
                            r_fed_blocks <= '0;
                            r_pix_cnt    <= '0;
                            r_state      <= S_ADMIT;
                        end
                    end
                end
                S_ADMIT: begin
                    if (w_credit_ok) begin
                        r_state <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (w_pix_hs) begin
                        r_pix_cnt <= r_pix_cnt + 6'd1;
                        if (r_pix_cnt == 6'd63) begin
                            r_fed_blocks <= r_fed_blocks + 16'd1;
                            r_state      <= w_last_fed ? S_DRAIN : S_ADMIT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_last_pop) begin
                        r_state      <= S_IDLE;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath reset: low during rst and for the single cycle after an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nrst <= 1'b0;
        end else begin
            r_nrst <= !abort;
        end
    end

    // Sticky error: coefficient arrived with no credit outstanding, or buffer full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_push_err) begin
            r_err <= 1'b1;
        end
    end

    // Buffer bookkeeping: pointers, occupancy, inflight credit and pop counters.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_pop_cnt  <= '0;
            r_coef_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (w_pop) begin
                r_rd      <= ptr_inc(r_rd);
                r_pop_cnt <= r_pop_cnt + 6'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_inflight <= r_inflight + (w_admit ? C_BLK : '0) - (w_dout_ok ? CW'(1) : '0);
            if (w_start_ok) begin
                r_coef_cnt <= '0;
            end else if (w_pop) begin
                r_coef_cnt <= r_coef_cnt + 22'd1;
            end
        end
    end

    // Coefficient storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= fdct_dout;
        end
    end

endmodule
